sha_mem_responder: RTL



---
 rtl/sha_mem_responder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sha_mem_responder.sv
// sha_mem_responder: word-addressed single-port-style RAM that serves the
// SHA-256 engine's memory port, plus a host-side control FSM that loads a
// message, starts the engine, waits for it and streams the hash back.
//
// Handshake rule for both host streams (load_* and res_*): a word moves on a
// rising clk edge where valid and ready are both high; the source holds its
// data stable while valid is high and ready is low.
module sha_mem_responder #(
  parameter int DEPTH        = 256,
  parameter int NUM_OF_WORDS = 20,
  parameter int OUT_WORDS    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] msg_base,
  input  logic [15:0] out_base,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_last,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        err,
  output logic [15:0] run_cycles,
  output logic [2:0]  dbg_state
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
  localparam logic [15:0] NW_L     = 16'(NUM_OF_WORDS);
  localparam logic [15:0] OW_LAST  = 16'(OUT_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_START      = 3'd2,
    S_RUN        = 3'd3,
    S_DRAIN_RD   = 3'd4,
    S_DRAIN_WAIT = 3'd5,
    S_DRAIN_HOLD = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] run_cycles_q, run_cycles_d;
  logic        load_ready_q, load_ready_d;
  logic        eng_start_q, eng_start_d;
  logic        res_valid_q, res_valid_d;
  logic        res_last_q, res_last_d;
  logic [31:0] res_data_q, res_data_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] mem_read_data_q, mem_read_data_d;

  logic [31:0] ram [DEPTH];

  logic        in_drain;
  logic        eng_phase;
  logic [15:0] rd_addr;
  logic [15:0] load_addr;
  logic        rd_in_range;
  logic        eng_wr_in_range;
  logic        ld_in_range;
  logic        load_hs;
  logic        eng_we;
  logic        err_set;

  // Address selection, range checks and write qualification
  always_comb begin
    in_drain        = (state_q == S_DRAIN_RD) || (state_q == S_DRAIN_WAIT) ||
                      (state_q == S_DRAIN_HOLD);
    eng_phase       = (state_q == S_START) || (state_q == S_RUN);
    // base + offset wraps in 16 bits before the range check
    rd_addr         = in_drain ? (out_base + ptr_q) : mem_addr;
    load_addr       = msg_base + cnt_q;
    rd_in_range     = ({1'b0, rd_addr} < DEPTH_L);
    eng_wr_in_range = ({1'b0, mem_addr} < DEPTH_L);
    ld_in_range     = ({1'b0, load_addr} < DEPTH_L);
    load_hs         = (state_q == S_LOAD) && load_ready_q && load_valid;
    eng_we          = eng_phase && mem_we;
    // Out-of-range engine/drain accesses and dropped message writes are flagged
    err_set         = ((eng_phase || in_drain) && !rd_in_range) ||
                      (load_hs && !ld_in_range);
    mem_read_data_d = rd_in_range ? ram[rd_addr[AW-1:0]] : 32'd0;
  end

  // RAM write port: engine writes in START/RUN, host message words in LOAD
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (eng_we && eng_wr_in_range) begin
        ram[mem_addr[AW-1:0]] <= mem_write_data;
      end else if (load_hs && ld_in_range) begin
        ram[load_addr[AW-1:0]] <= load_data;
      end
    end
  end

  // Control FSM next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    run_cycles_d = run_cycles_q;
    load_ready_d = load_ready_q;
    eng_start_d  = eng_start_q;
    res_valid_d  = res_valid_q;
    res_last_d   = res_last_q;
    res_data_d   = res_data_q;
    err_d        = err_q | err_set;
    case (state_q)
      S_IDLE: begin
        // The first valid only opens the load; the word is taken next cycle
        if (load_valid) begin
          state_d      = S_LOAD;
          load_ready_d = 1'b1;
          cnt_d        = 16'd0;
          run_cycles_d = 16'd0;
          err_d        = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_hs) begin
          cnt_d = cnt_q + 16'd1;
          if (((cnt_q + 16'd1) >= NW_L) || load_last) begin
            state_d      = S_START;
            load_ready_d = 1'b0;
            eng_start_d  = 1'b1;
          end
        end
      end
      S_START: begin
        if (!eng_done) begin
          state_d     = S_RUN;
          eng_start_d = 1'b0;
        end
      end
      S_RUN: begin
        if (run_cycles_q != 16'hFFFF) begin
          run_cycles_d = run_cycles_q + 16'd1;
        end
        if (eng_done) begin
          state_d = S_DRAIN_RD;
          ptr_d   = 16'd0;
        end
      end
      S_DRAIN_RD: begin
        state_d = S_DRAIN_WAIT;
      end
      S_DRAIN_WAIT: begin
        res_data_d  = mem_read_data_q;
        res_valid_d = 1'b1;
        res_last_d  = (ptr_q == OW_LAST);
        state_d     = S_DRAIN_HOLD;
      end
      S_DRAIN_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          if (res_last_q) begin
            state_d = S_IDLE;
          end else begin
            ptr_d   = ptr_q + 16'd1;
            state_d = S_DRAIN_RD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 16'd0;
      ptr_q           <= 16'd0;
      run_cycles_q    <= 16'd0;
      load_ready_q    <= 1'b0;
      eng_start_q     <= 1'b0;
      res_valid_q     <= 1'b0;
      res_last_q      <= 1'b0;
      res_data_q      <= 32'd0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      mem_read_data_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ptr_q           <= ptr_d;
      run_cycles_q    <= run_cycles_d;
      load_ready_q    <= load_ready_d;
      eng_start_q     <= eng_start_d;
      res_valid_q     <= res_valid_d;
      res_last_q      <= res_last_d;
      res_data_q      <= res_data_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      mem_read_data_q <= mem_read_data_d;
    end
  end

  assign load_ready    = load_ready_q;
  assign eng_start     = eng_start_q;
  assign res_valid     = res_valid_q;
  assign res_last      = res_last_q;
  assign res_data      = res_data_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign run_cycles    = run_cycles_q;
  assign mem_read_data = mem_read_data_q;
  assign dbg_state     = state_q;

endmodule
